// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM state encoding and protocol constants.
// Imported by the receiver and available to the downstream scancode stages.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_state_e;

   localparam int PS2_DATA_BITS = 8;

   // Key-release prefix byte; the decoder uses it to drop the following code.
   localparam logic [7:0] PS2_BREAK = 8'hF0;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for the PS/2 pad signals plus a falling-edge
// detector on the synchronised PS/2 clock.
module ps2_sync_edge (
   input  logic clk,
   input  logic areset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic data_s,
   output logic fall
);

   logic [1:0] clk_sync;
   logic [1:0] data_sync;
   logic       clk_prev;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, which is what makes the
   // shift chain a two-stage synchroniser rather than a single wire.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_prev  <= clk_sync[1];
      end
   end

   assign data_s = data_sync[1];
   assign fall   = clk_prev & ~clk_sync[1];

endmodule

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: frames start/8 data/odd parity/stop, emits one
// code_valid strobe per clean byte and an err strobe for any bad or stalled frame.
module ps2_rx_byte
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2000
) (
   input  logic       clk,
   input  logic       areset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       err,
   output logic       busy
);

   localparam int TW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int CW  = $clog2(PS2_DATA_BITS);

   logic                     data_s;
   logic                     fall;
   logic                     timeout;

   ps2_state_e               state_q, state_d;
   logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     par_q, par_d;
   logic [TW-1:0]            tcnt_q, tcnt_d;
   logic [7:0]               code_d;
   logic                     valid_d, err_d;

   ps2_sync_edge u_sync (
      .clk     (clk),
      .areset  (areset),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .data_s  (data_s),
      .fall    (fall)
   );

   // NOTE: every signal driven here gets a default before any branch, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      code_d  = code;
      valid_d = 1'b0;
      err_d   = 1'b0;

      // An edge in the same cycle as the expiry keeps the frame alive.
      timeout = (state_q != ST_IDLE) && !fall && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
      tcnt_d  = (state_q == ST_IDLE || fall) ? '0 : tcnt_q + TW'(1);

      if (timeout) begin
         state_d = ST_IDLE;
         shift_d = '0;
         cnt_d   = '0;
         err_d   = 1'b1;
      end else if (fall) begin
         case (state_q)
            ST_IDLE: begin
               if (!data_s) begin
                  state_d = ST_DATA;
                  cnt_d   = '0;
               end
            end
            ST_DATA: begin
               shift_d = {data_s, shift_q[PS2_DATA_BITS-1:1]};
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CW'(PS2_DATA_BITS - 1))
                  state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_d   = data_s;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (data_s && (^{shift_q, par_q})) begin
                  code_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         par_q      <= 1'b0;
         tcnt_q     <= '0;
         code       <= 8'h00;
         code_valid <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         par_q      <= par_d;
         tcnt_q     <= tcnt_d;
         code       <= code_d;
         code_valid <= valid_d;
         err        <= err_d;
      end
   end

   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_rx_byte.sv
// Directed bench for ps2_rx_byte: drives PS/2 frames at the pad and checks
// decoded bytes, error strobes, busy and pad-to-strobe latency.
module tb_ps2_rx_byte;

   localparam int T    = 2000;
   localparam int HALF = 5;

   logic       clk = 1'b0;
   logic       areset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] code;
   logic       code_valid;
   logic       err;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_errp = 0;
   int last_valid_cyc = 0;
   int last_err_cyc = 0;
   int both_seen = 0;
   int last_fall_cyc = 0;
   int stop_fall_cyc = 0;

   ps2_rx_byte #(.TIMEOUT_CYCLES(T)) dut (
      .clk       (clk),
      .areset    (areset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .code      (code),
      .code_valid(code_valid),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (code_valid) begin
         n_valid = n_valid + 1;
         last_valid_cyc = cyc;
      end
      if (err) begin
         n_errp = n_errp + 1;
         last_err_cyc = cyc;
      end
      if (code_valid && err) both_seen = both_seen + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic send_bit(input logic b);
      @(negedge clk) ps2_data = b;
      repeat (HALF) @(posedge clk);
      @(negedge clk) ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(posedge clk);
      @(negedge clk) ps2_clk = 1'b1;
      repeat (HALF) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(p);
      send_bit(s);
      stop_fall_cyc = last_fall_cyc;
   endtask

   task automatic test_reset();
      int v0, e0, busy_seen;
      @(negedge clk);
      n_cmp++; if (code !== 8'h00) begin n_bad++; $display("FAIL reset_code: got %h want 00", code); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (code_valid !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_strobes: valid %b err %b want 0 0", code_valid, err); end
      areset = 1'b0;
      v0 = n_valid; e0 = n_errp; busy_seen = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_seen++;
      end
      n_cmp++; if (busy_seen != 0) begin n_bad++; $display("FAIL idle_busy: %0d busy cycles want 0", busy_seen); end
      n_cmp++; if (n_valid - v0 != 0 || n_errp - e0 != 0) begin n_bad++; $display("FAIL idle_strobes: valid %0d err %0d want 0 0", n_valid - v0, n_errp - e0); end
      n_cmp++; if (code !== 8'h00) begin n_bad++; $display("FAIL idle_code: got %h want 00", code); end
   endtask

   task automatic test_back_to_back();
      int v0, e0;
      v0 = n_valid; e0 = n_errp;
      send_frame(8'h45, 1'b0, 1'b1);
      n_cmp++; if (n_valid - v0 != 1) begin n_bad++; $display("FAIL b2b_first_count: got %0d want 1", n_valid - v0); end
      n_cmp++; if (code !== 8'h45) begin n_bad++; $display("FAIL b2b_first_code: got %h want 45", code); end
      n_cmp++; if (last_valid_cyc - stop_fall_cyc != 3) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 3", last_valid_cyc - stop_fall_cyc); end
      send_frame(8'h16, 1'b0, 1'b1);
      n_cmp++; if (n_valid - v0 != 2) begin n_bad++; $display("FAIL b2b_second_count: got %0d want 2", n_valid - v0); end
      n_cmp++; if (code !== 8'h16) begin n_bad++; $display("FAIL b2b_second_code: got %h want 16", code); end
      n_cmp++; if (last_valid_cyc - stop_fall_cyc != 3) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 3", last_valid_cyc - stop_fall_cyc); end
      n_cmp++; if (n_errp - e0 != 0) begin n_bad++; $display("FAIL b2b_err: got %0d want 0", n_errp - e0); end
   endtask

   task automatic test_parity();
      int v0, e0;
      v0 = n_valid; e0 = n_errp;
      send_frame(8'hF0, 1'b1, 1'b1);
      n_cmp++; if (n_valid - v0 != 1 || code !== 8'hF0) begin n_bad++; $display("FAIL parity_good: valid %0d code %h want 1 f0", n_valid - v0, code); end
      v0 = n_valid;
      send_frame(8'h45, 1'b1, 1'b1);
      n_cmp++; if (n_errp - e0 != 1) begin n_bad++; $display("FAIL parity_bad_err: got %0d want 1", n_errp - e0); end
      n_cmp++; if (n_valid - v0 != 0) begin n_bad++; $display("FAIL parity_bad_valid: got %0d want 0", n_valid - v0); end
      n_cmp++; if (code !== 8'hF0) begin n_bad++; $display("FAIL parity_bad_code: got %h want f0", code); end
      n_cmp++; if (last_err_cyc - stop_fall_cyc != 3) begin n_bad++; $display("FAIL parity_err_latency: got %0d want 3", last_err_cyc - stop_fall_cyc); end
   endtask

   task automatic test_stop_bit();
      int v0, e0;
      v0 = n_valid; e0 = n_errp;
      send_frame(8'h45, 1'b0, 1'b0);
      n_cmp++; if (n_errp - e0 != 1 || n_valid - v0 != 0) begin n_bad++; $display("FAIL stop_bad: err %0d valid %0d want 1 0", n_errp - e0, n_valid - v0); end
      n_cmp++; if (code !== 8'hF0) begin n_bad++; $display("FAIL stop_bad_code: got %h want f0", code); end
      send_frame(8'h16, 1'b0, 1'b1);
      n_cmp++; if (code !== 8'h16 || n_valid - v0 != 1) begin n_bad++; $display("FAIL stop_recover: code %h valid %0d want 16 1", code, n_valid - v0); end
   endtask

   task automatic test_timeout();
      int v0, e0, f;
      v0 = n_valid; e0 = n_errp;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      f = last_fall_cyc;
      while (cyc < f + T) @(negedge clk);
      n_cmp++; if (busy !== 1'b1 || n_errp - e0 != 0) begin n_bad++; $display("FAIL timeout_early: busy %b err %0d want 1 0", busy, n_errp - e0); end
      repeat (20) @(negedge clk);
      n_cmp++; if (n_errp - e0 != 1) begin n_bad++; $display("FAIL timeout_err_count: got %0d want 1", n_errp - e0); end
      n_cmp++; if (last_err_cyc != f + T + 3) begin n_bad++; $display("FAIL timeout_err_cycle: got %0d want %0d", last_err_cyc, f + T + 3); end
      n_cmp++; if (busy !== 1'b0 || n_valid - v0 != 0) begin n_bad++; $display("FAIL timeout_idle: busy %b valid %0d want 0 0", busy, n_valid - v0); end
      send_frame(8'h45, 1'b0, 1'b1);
      n_cmp++; if (code !== 8'h45 || n_valid - v0 != 1) begin n_bad++; $display("FAIL timeout_recover: code %h valid %0d want 45 1", code, n_valid - v0); end
   endtask

   task automatic test_idle_edge();
      int v0, e0;
      v0 = n_valid; e0 = n_errp;
      send_bit(1'b1);
      n_cmp++; if (busy !== 1'b0 || n_errp - e0 != 0) begin n_bad++; $display("FAIL idle_edge: busy %b err %0d want 0 0", busy, n_errp - e0); end
      send_frame(8'h26, 1'b0, 1'b1);
      n_cmp++; if (code !== 8'h26 || n_valid - v0 != 1 || n_errp - e0 != 0) begin n_bad++; $display("FAIL idle_edge_recover: code %h valid %0d err %0d want 26 1 0", code, n_valid - v0, n_errp - e0); end
   endtask

   task automatic test_reset_midframe();
      int v0, e0;
      logic [7:0] d;
      d = 8'h26;
      v0 = n_valid; e0 = n_errp;
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(d[i]);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midframe_busy: got %b want 1", busy); end
      @(negedge clk) areset = 1'b1;
      #1;
      n_cmp++; if (code !== 8'h00 || busy !== 1'b0 || code_valid !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL midframe_reset: code %h busy %b valid %b err %b want 00 0 0 0", code, busy, code_valid, err); end
      repeat (4) @(negedge clk);
      areset = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++; if (n_errp - e0 != 0 || n_valid - v0 != 0) begin n_bad++; $display("FAIL midframe_strobes: err %0d valid %0d want 0 0", n_errp - e0, n_valid - v0); end
      send_frame(8'h26, 1'b0, 1'b1);
      n_cmp++; if (code !== 8'h26 || n_valid - v0 != 1) begin n_bad++; $display("FAIL midframe_recover: code %h valid %0d want 26 1", code, n_valid - v0); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_parity();
      test_stop_bit();
      test_timeout();
      test_idle_edge();
      test_reset_midframe();
      n_cmp++; if (both_seen != 0) begin n_bad++; $display("FAIL exclusive_strobes: %0d cycles with both high want 0", both_seen); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ps2_rx_byte.md
# ps2_rx_byte

Deserialises the PS/2 keyboard serial link into 8-bit scancode bytes, one valid strobe per correctly framed byte. It sits directly upstream of the scancode-to-digit decoder and drives that stage's `code` input. Framing errors, parity errors and stalled frames are flagged and discarded, so downstream stages see only clean bytes.

## Interface
- `TIMEOUT_CYCLES`, default 2000: `clk` cycles allowed between consecutive PS/2 clock falling edges inside a frame before the frame is aborted.
- `clk`  in  1  system clock; all logic on the rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock from the pad; asynchronous to `clk`; idles high.
- `ps2_data`  in  1  raw PS/2 data from the pad; asynchronous; idles high.
- `code`  out  8  last correctly received byte; holds until the next good frame.
- `code_valid`  out  1  one-cycle pulse; `code` is new in this cycle.
- `err`  out  1  one-cycle pulse: bad start/stop, parity or timeout.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- Two-flop synchroniser on each of `ps2_clk` and `ps2_data`. Sync flops reset to 1.
- `fall` = previous synced `ps2_clk` is 1 and current synced `ps2_clk` is 0. `ps2_data` is sampled (synced) only in cycles where `fall` is high.
- Frame format: 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1).
- FSM states and transitions:
  - IDLE: on `fall` with data 0, go to DATA with bit count 0. On `fall` with data 1, stay in IDLE; the edge is ignored and `err` is not raised.
  - DATA: on each `fall`, shift the bit into the MSB of the shift register (right shift) and increment the count. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, return to IDLE.
    - If data is 1 and the XOR of the 8 data bits and the parity bit is 1, load `code` and pulse `code_valid`.
    - Otherwise pulse `err` and leave `code` unchanged.
- Timeout counter:
  - Clears on every `fall` and in IDLE; counts otherwise.
  - In a non-IDLE state, when it reaches `TIMEOUT_CYCLES-1`, the block pulses `err`, returns to IDLE and discards the partial byte.
  - If `fall` and timeout coincide, `fall` wins.
- `code_valid` and `err` are never high in the same cycle.
- Reset values: state IDLE, shift register 0, count 0, timeout 0, `code`=8'h00, `code_valid`=0, `err`=0, `busy`=0.
- Reset asserted mid-frame aborts the frame immediately, with no `err` pulse. A frame already in progress when reset deasserts is received as garbage and rejected by the start/stop/parity checks or by the timeout.

## Timing
- Input latency: a `ps2_clk` low first sampled at rising edge k produces `fall` in the cycle after edge k+1. The FSM acts on edge k+2.
- Output latency: `code_valid`/`err` are registered and high for exactly the one cycle after the edge on which the FSM acts on the stop-bit `fall`.
- Each `ps2_clk` high and low phase must last at least 3 `clk` cycles. At the nominal 10–16.7 kHz PS/2 clock with `clk` ≥ 1 MHz this holds.
- Back-to-back frames need no gap: the start-bit `fall` may arrive at any time after the stop-bit `fall`.
- `busy` rises in the cycle after the start-bit edge is accepted and falls in the cycle after the stop-bit edge or timeout.

## Structure
- Shared package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - `PS2_DATA_BITS`=8.
  - Break prefix constant `PS2_BREAK`=8'hF0, for downstream use.
- Sub-module `ps2_sync_edge`: the two-flop synchronisers plus the falling-edge detector. Outputs synced data and `fall`. All remaining logic lives in the top module.

## Test plan
- Reset, then idle lines for 5000 cycles -> `code`=8'h00; `code_valid`, `err` and `busy` stay 0; no timeout fires from IDLE.
- Send frame 0x45 (parity 0), then immediately frame 0x16 (parity 0) -> two `code_valid` pulses with `code`=8'h45 then 8'h16, each exactly 3 `clk` cycles after the stop-bit fall at the pad; `err`=0.
- Send 0xF0 with parity 1 -> `code`=8'hF0 with `code_valid`. Then send 0x45 with parity 1 (bad) -> one `err` pulse, no `code_valid`, `code` stays 8'hF0.
- Send 0x45 with stop bit 0 -> `err` pulse, `code` unchanged. A following good 0x16 frame -> `code`=8'h16.
- Send start plus 3 data bits, then hold `ps2_clk` high for `TIMEOUT_CYCLES` -> single `err` pulse at count `TIMEOUT_CYCLES-1` and `busy`=0. The next good 0x45 frame is decoded.
- Two further cases, each followed by a full good 0x26 frame that must decode to 8'h26:
  - Falling `ps2_clk` with data 1 while idle -> ignored, no `err`.
  - `areset` asserted after 5 data bits -> all outputs return to reset values at once, no `err`.
